// File: rtl/cannon_sequencer.sv
// ---------------------------------------------------------------------------
// cannon_sequencer
//
// Control FSM for a Cannon-style block matrix multiply on a SQRT_P x SQRT_P
// processor grid. A run clears the accumulators, loads the tiles, and then
// does SQRT_P rounds. Each round is a MUL_LAT-cycle multiply window followed
// by an accumulate. A rotate of the A/B tiles separates consecutive rounds.
// All outputs are decoded from registered state only.
//
// Parameters:
//   SQRT_P   grid side and number of multiply/accumulate rounds (1..16)
//   MUL_LAT  cycles the multiply window is held per round (1..15)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        begin one run; sampled only in IDLE
//   abort        synchronous cancel of a run in progress (beats start)
//   enable_read  load block tiles (READ)
//   clear_sum    zero accumulator tiles (CLEAR)
//   enable_mul   block-multiply window (MUL, MUL_LAT cycles per round)
//   enable_sum   accumulate block products (SUM)
//   enable_shift rotate A along rows, B along columns (SHIFT)
//   busy         high in every state except IDLE
//   done         one-cycle pulse at normal completion (DONE)
//   round        0-based index of the current round
// ---------------------------------------------------------------------------
module cannon_sequencer #(
  parameter int SQRT_P  = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  output logic                      enable_read,
  output logic                      clear_sum,
  output logic                      enable_mul,
  output logic                      enable_sum,
  output logic                      enable_shift,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(SQRT_P):0]   round
);

  localparam int RW = $clog2(SQRT_P) + 1;
  localparam int CW = $clog2(MUL_LAT) + 1;
  localparam logic [RW-1:0] LastRound = RW'(SQRT_P - 1);
  localparam logic [CW-1:0] LastDwell = CW'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    READ  = 3'd2,
    MUL   = 3'd3,
    SUM   = 3'd4,
    SHIFT = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [CW-1:0] dwell_q, dwell_d;

  // State, round index and MUL dwell counter registers. Reset drops
  // everything back to IDLE with both counters cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      dwell_q <= dwell_d;
    end
  end

  // Next-state logic. Abort overrides everything outside IDLE. The dwell
  // counter is zeroed on every path into MUL (from READ and from SHIFT).
  // Inside MUL it counts up to MUL_LAT-1 and then stops, so it cannot wrap.
  // The round index only advances on the SHIFT->MUL edge.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    dwell_d = dwell_q;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      round_d = '0;
      dwell_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          round_d = '0;
          dwell_d = '0;
          if (start && !abort) state_d = CLEAR;
        end
        CLEAR: state_d = READ;
        READ: begin
          state_d = MUL;
          dwell_d = '0;
        end
        MUL: begin
          if (dwell_q == LastDwell) state_d = SUM;
          else                      dwell_d = dwell_q + 1'b1;
        end
        SUM: begin
          if (round_q < LastRound) state_d = SHIFT;
          else                     state_d = DONE;
        end
        SHIFT: begin
          state_d = MUL;
          round_d = round_q + 1'b1;
          dwell_d = '0;
        end
        DONE: begin
          state_d = IDLE;
          round_d = '0;
        end
        default: begin
          state_d = IDLE;
          round_d = '0;
          dwell_d = '0;
        end
      endcase
    end
  end

  // Moore output decode. Each strobe belongs to exactly one state, so the
  // strobes are mutually exclusive.
  always_comb begin
    clear_sum    = 1'b0;
    enable_read  = 1'b0;
    enable_mul   = 1'b0;
    enable_sum   = 1'b0;
    enable_shift = 1'b0;
    done         = 1'b0;
    case (state_q)
      CLEAR:   clear_sum    = 1'b1;
      READ:    enable_read  = 1'b1;
      MUL:     enable_mul   = 1'b1;
      SUM:     enable_sum   = 1'b1;
      SHIFT:   enable_shift = 1'b1;
      DONE:    done         = 1'b1;
      default: ;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign round = round_q;

endmodule

// File: tb/tb_cannon_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cannon_sequencer
//
// Drives three sequencer instances from shared start/abort/rst stimulus:
//   dut0: SQRT_P=2, MUL_LAT=1 (defaults)
//   dut1: SQRT_P=3, MUL_LAT=2
//   dut2: SQRT_P=1, MUL_LAT=1
// The reference tracks each instance as "idle" or "cycle i of a run".
// Expected outputs are computed arithmetically from the run layout:
//   CLEAR, READ, then per round MUL x MUL_LAT, SUM, SHIFT (except after the
//   last round), then DONE.
// ---------------------------------------------------------------------------
module tb_cannon_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;

  logic [2:0] rdO, clrO, mulO, sumO, shfO, busyO, doneO;
  logic [1:0] round0;
  logic [2:0] round1;
  logic [0:0] round2;

  int spTab[3] = '{2, 3, 1};
  int mlTab[3] = '{1, 2, 1};

  bit active[3];
  int idx[3];

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  cannon_sequencer #(.SQRT_P(2), .MUL_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .enable_read(rdO[0]), .clear_sum(clrO[0]), .enable_mul(mulO[0]),
    .enable_sum(sumO[0]), .enable_shift(shfO[0]), .busy(busyO[0]),
    .done(doneO[0]), .round(round0)
  );

  cannon_sequencer #(.SQRT_P(3), .MUL_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .enable_read(rdO[1]), .clear_sum(clrO[1]), .enable_mul(mulO[1]),
    .enable_sum(sumO[1]), .enable_shift(shfO[1]), .busy(busyO[1]),
    .done(doneO[1]), .round(round1)
  );

  cannon_sequencer #(.SQRT_P(1), .MUL_LAT(1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .enable_read(rdO[2]), .clear_sum(clrO[2]), .enable_mul(mulO[2]),
    .enable_sum(sumO[2]), .enable_shift(shfO[2]), .busy(busyO[2]),
    .done(doneO[2]), .round(round2)
  );

  // Expected {busy, clear, read, mul, sum, shift, done, round[7:0]}.
  function automatic logic [14:0] expected(int sp, int ml, bit a, int i);
    logic [6:0] v;
    int r;
    int len;
    int k;
    int m;
    v   = '0;
    r   = 0;
    len = sp * (ml + 2) + 2;
    if (a) begin
      v[6] = 1'b1;
      if (i == 0)             v[5] = 1'b1;
      else if (i == 1)        v[4] = 1'b1;
      else if (i == len - 1) begin
        v[0] = 1'b1;
        r    = sp - 1;
      end else begin
        k = i - 2;
        r = k / (ml + 2);
        m = k % (ml + 2);
        if (m < ml)       v[3] = 1'b1;
        else if (m == ml) v[2] = 1'b1;
        else              v[1] = 1'b1;
      end
    end
    return {v, 8'(r)};
  endfunction

  function automatic logic [14:0] observed(int n);
    logic [7:0] r;
    case (n)
      0:       r = 8'(round0);
      1:       r = 8'(round1);
      default: r = 8'(round2);
    endcase
    return {busyO[n], clrO[n], rdO[n], mulO[n], sumO[n], shfO[n], doneO[n], r};
  endfunction

  // Advance the reference across one rising edge.
  task automatic modelEdge(input logic s, input logic a);
    for (int n = 0; n < 3; n++) begin
      if (rst) begin
        active[n] = 1'b0;
        idx[n]    = 0;
      end else if (active[n]) begin
        if (a || (idx[n] == spTab[n] * (mlTab[n] + 2) + 1)) begin
          active[n] = 1'b0;
          idx[n]    = 0;
        end else begin
          idx[n] = idx[n] + 1;
        end
      end else if (s && !a) begin
        active[n] = 1'b1;
        idx[n]    = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [14:0] obs;
    logic [14:0] exp;
    for (int n = 0; n < 3; n++) begin
      obs = observed(n);
      exp = expected(spTab[n], mlTab[n], active[n], idx[n]);
      nChecks++;
      assert (obs === exp)
      else begin
        nFails++;
        $error("[TB] FAIL %s dut%0d observed=%h expected=%h", tag, n, obs, exp);
      end
    end
  endtask

  // Drive inputs, take one edge, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic s, input logic a, input string tag);
    start = s;
    abort = a;
    @(posedge clk);
    modelEdge(s, a);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    for (int n = 0; n < 3; n++) begin
      active[n] = 1'b0;
      idx[n]    = 0;
    end
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    #2;
    checkOutput("reset_state");
    @(posedge clk);
    #3;
    rst = 1'b0;

    // Single start pulse; long enough to drain the longest run.
    applyStimulus(1'b1, 1'b0, "single_start");
    for (int c = 0; c < 16; c++) applyStimulus(1'b0, 1'b0, "single_run");

    // Abort during the second MUL of the default configuration.
    applyStimulus(1'b1, 1'b0, "abort_start");
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, "abort_pre");
    applyStimulus(1'b0, 1'b1, "abort_hit");
    applyStimulus(1'b0, 1'b0, "abort_idle");
    applyStimulus(1'b1, 1'b0, "after_abort_start");
    for (int c = 0; c < 15; c++) applyStimulus(1'b0, 1'b0, "after_abort_run");

    // Abort together with start while idle keeps everything idle.
    applyStimulus(1'b1, 1'b1, "abort_start_idle");
    applyStimulus(1'b0, 1'b0, "abort_start_idle2");

    // Start held high: back-to-back runs, one IDLE cycle between them.
    for (int c = 0; c < 40; c++) applyStimulus(1'b1, 1'b0, "start_held");
    for (int c = 0; c < 16; c++) applyStimulus(1'b0, 1'b0, "held_drain");

    // Asynchronous reset between edges while dut0 sits in SUM.
    applyStimulus(1'b1, 1'b0, "rst_run_start");
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, "rst_run");
    #2;
    rst = 1'b1;
    #1;
    modelEdge(1'b0, 1'b0);
    checkOutput("async_reset");
    @(posedge clk);
    #1;
    checkOutput("reset_hold");
    #3;
    rst = 1'b0;
    for (int c = 0; c < 16; c++) applyStimulus(1'b0, 1'b0, "post_reset_quiet");
    applyStimulus(1'b1, 1'b0, "post_reset_start");

    // Randomized start/abort traffic.
    for (int c = 0; c < 300; c++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                    "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
